// File: rtl/pad_out_turnaround_pkg.sv
// Shared types and helpers for the output-side pad turnaround controller.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        HIZ      = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } pad_turn_state_e;

    // Guard counter width: holds values up to turn_cycles, never narrower than 1 bit.
    function automatic int turn_cnt_width(input int turn_cycles);
        int w;
        if (turn_cycles < 1) begin
            w = 1;
        end else begin
            w = $clog2(turn_cycles + 1);
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Attribute bus width; a zero-width request still gets one bit.
    function automatic int attr_width(input int padattr);
        return (padattr == 0) ? 1 : padattr;
    endfunction

endpackage

// File: rtl/pad_out_turnaround_if.sv
// Core-to-pad-ring bundle for the output turnaround controller.
// master: pad-control logic side, slave: the turnaround controller.
interface pad_out_turnaround_if #(
    parameter int PADATTR = 16
);
    localparam int PADATTR_RND = pad_ctrl_pkg::attr_width(PADATTR);

    logic                   pad_out_i;
    logic                   pad_oe_i;
    logic                   od_i;
    logic [PADATTR_RND-1:0] pad_attributes_i;

    logic                   pad_o;
    logic                   pad_oe_o;
    logic [PADATTR_RND-1:0] pad_attr_o;
    logic                   in_valid_o;
    logic                   busy_o;

    modport master (
        output pad_out_i,
        output pad_oe_i,
        output od_i,
        output pad_attributes_i,
        input  pad_o,
        input  pad_oe_o,
        input  pad_attr_o,
        input  in_valid_o,
        input  busy_o
    );

    modport slave (
        input  pad_out_i,
        input  pad_oe_i,
        input  od_i,
        input  pad_attributes_i,
        output pad_o,
        output pad_oe_o,
        output pad_attr_o,
        output in_valid_o,
        output busy_o
    );

endinterface

// File: rtl/pad_out_turnaround_cnt.sv
// Loadable down-counter timing the hi-Z guard interval of both turnarounds.
module pad_turn_cnt #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Zero flag drives the turnaround exit decision.
    always_comb begin
        zero_o = (cnt_q == '0);
    end

endmodule

// File: rtl/pad_out_turnaround.sv
// Output-side bidirectional pad controller: registers core data/enable,
// applies pad attributes while released, and inserts TURN_CYCLES hi-Z guard
// cycles on every direction change so pad and external device never fight.
// Optional build macro PAD_TURN_ABORT_EN: a request dropped during TURN_ON
// returns straight to HIZ (the pad was never driven). TURN_OFF always completes.
module pad_out_turnaround
    import pad_ctrl_pkg::*;
#(
    parameter int PADATTR     = 16,
    parameter int TURN_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pad_out_turnaround_if.slave  pad
);

    localparam int PADATTR_RND = attr_width(PADATTR);
    localparam int CNT_W       = turn_cnt_width(TURN_CYCLES);
    localparam bit DIRECT      = (TURN_CYCLES == 0);
    localparam logic [CNT_W-1:0] LOAD_VAL =
        DIRECT ? '0 : CNT_W'(TURN_CYCLES - 1);

    pad_turn_state_e        state_q;
    pad_turn_state_e        state_next;
    logic                   oe_req_q;
    logic                   data_q;
    logic                   od_mode_q;
    logic [PADATTR_RND-1:0] attr_q;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_zero;

    pad_turn_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero_o   (cnt_zero)
    );

    // Direction request is registered so the FSM never reacts to a raw input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oe_req_q <= 1'b0;
        end else begin
            oe_req_q <= pad.pad_oe_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HIZ;
        end else begin
            state_q <= state_next;
        end
    end

    // Data and drive mode are captured on every cycle that ends in DRIVE,
    // including the entry edge, so the first drive cycle shows fresh data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= 1'b0;
            od_mode_q <= 1'b0;
        end else if (state_next == DRIVE) begin
            data_q    <= pad.pad_out_i;
            od_mode_q <= pad.od_i;
        end
    end

    // Attributes follow the request only while the pad is released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            attr_q <= '0;
        end else if (state_q == HIZ) begin
            attr_q <= pad.pad_attributes_i;
        end
    end

    // Next-state and guard-counter control.
    always_comb begin
        state_next = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            HIZ: begin
                if (oe_req_q) begin
                    if (DIRECT) begin
                        state_next = DRIVE;
                    end else begin
                        state_next = TURN_ON;
                        cnt_load   = 1'b1;
                    end
                end
            end
            TURN_ON: begin
`ifdef PAD_TURN_ABORT_EN
                if (!oe_req_q) begin
                    state_next = HIZ;
                end else if (cnt_zero) begin
                    state_next = DRIVE;
                end else begin
                    cnt_dec = 1'b1;
                end
`else
                if (cnt_zero) begin
                    state_next = DRIVE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            DRIVE: begin
                if (!oe_req_q) begin
                    if (DIRECT) begin
                        state_next = HIZ;
                    end else begin
                        state_next = TURN_OFF;
                        cnt_load   = 1'b1;
                    end
                end
            end
            TURN_OFF: begin
                if (cnt_zero) begin
                    state_next = HIZ;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_next = HIZ;
            end
        endcase
    end

    // Pad-side outputs decoded purely from registered state.
    always_comb begin
        pad.pad_o      = 1'b0;
        pad.pad_oe_o   = 1'b0;
        pad.in_valid_o = 1'b0;
        pad.busy_o     = 1'b0;
        pad.pad_attr_o = attr_q;
        case (state_q)
            HIZ: begin
                pad.in_valid_o = 1'b1;
            end
            TURN_ON, TURN_OFF: begin
                pad.busy_o = 1'b1;
            end
            DRIVE: begin
                if (od_mode_q) begin
                    pad.pad_oe_o = ~data_q;
                end else begin
                    pad.pad_oe_o = 1'b1;
                    pad.pad_o    = data_q;
                end
            end
            default: begin
                pad.in_valid_o = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    // The pad must never drive while the input side believes its data is valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && pad.pad_oe_o && pad.in_valid_o) begin
            $error("pad_out_turnaround: pad_oe_o and in_valid_o both high");
        end
    end
`endif

endmodule

// File: tb/tb_pad_out_turnaround.sv
// Scoreboard bench for pad_out_turnaround: dut_a uses TURN_CYCLES=2,
// dut_b uses TURN_CYCLES=3; both see the same core-side stimulus.
module tb_pad_out_turnaround;

    typedef logic [18:0] stim_t; // {pad_oe_i, pad_out_i, od_i, pad_attributes_i}
    typedef logic [19:0] exp_t;  // {pad_o, pad_oe_o, in_valid_o, busy_o, pad_attr_o}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pad_out = 1'b0;
    logic        pad_oe = 1'b0;
    logic        od = 1'b0;
    logic [15:0] attr = 16'hA5A5;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;
    exp_t        sb[$];

    pad_out_turnaround_if #(.PADATTR(16)) bus_a ();
    pad_out_turnaround_if #(.PADATTR(16)) bus_b ();

    assign bus_a.pad_out_i        = pad_out;
    assign bus_a.pad_oe_i         = pad_oe;
    assign bus_a.od_i             = od;
    assign bus_a.pad_attributes_i = attr;
    assign bus_b.pad_out_i        = pad_out;
    assign bus_b.pad_oe_i         = pad_oe;
    assign bus_b.od_i             = od;
    assign bus_b.pad_attributes_i = attr;

    pad_out_turnaround #(.PADATTR(16), .TURN_CYCLES(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .pad   (bus_a)
    );

    pad_out_turnaround #(.PADATTR(16), .TURN_CYCLES(3)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .pad   (bus_b)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs(input bit sel);
        if (sel) begin
            return {bus_b.pad_o, bus_b.pad_oe_o, bus_b.in_valid_o, bus_b.busy_o, bus_b.pad_attr_o};
        end
        return {bus_a.pad_o, bus_a.pad_oe_o, bus_a.in_valid_o, bus_a.busy_o, bus_a.pad_attr_o};
    endfunction

    task automatic drive(input stim_t s);
        {pad_oe, pad_out, od, attr} = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st [3];
        exp_t  ex [3];
        exp_t  e, g;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            g = obs(d[0]);
            checks++;
            if (g !== {4'b0010, 16'h0000}) begin
                fails++;
                $display("FAIL reset_state dut%0d got=%h exp=%h", d, g, {4'b0010, 16'h0000});
            end else passes++;
        end
        rst = 1'b0;
        st = '{{3'b000, 16'hA5A5}, {3'b000, 16'h1234}, {3'b000, 16'hA5A5}};
        ex = '{{4'b0010, 16'hA5A5}, {4'b0010, 16'h1234}, {4'b0010, 16'hA5A5}};
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b0);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL hiz_attr[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
    endtask

    task automatic test_turn_on();
        stim_t st [4];
        exp_t  ex [4];
        exp_t  e, g;
        st = '{{3'b110, 16'hA5A5}, {3'b110, 16'hA5A5}, {3'b110, 16'hA5A5}, {3'b110, 16'hA5A5}};
        ex = '{{4'b0010, 16'hA5A5}, {4'b0001, 16'hA5A5}, {4'b0001, 16'hA5A5}, {4'b1100, 16'hA5A5}};
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b0);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL turn_on[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
    endtask

    task automatic test_drive_data();
        stim_t st [4];
        exp_t  ex [4];
        exp_t  e, g;
        st = '{{3'b100, 16'h00FF}, {3'b110, 16'h00FF}, {3'b100, 16'h00FF}, {3'b110, 16'h00FF}};
        ex = '{{4'b0100, 16'hA5A5}, {4'b1100, 16'hA5A5}, {4'b0100, 16'hA5A5}, {4'b1100, 16'hA5A5}};
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b0);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL drive_data[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
    endtask

    task automatic test_turn_off();
        stim_t st [5];
        exp_t  ex [5];
        exp_t  e, g;
        st = '{{3'b010, 16'h00FF}, {3'b010, 16'h00FF}, {3'b010, 16'h00FF},
               {3'b010, 16'h00FF}, {3'b010, 16'h00FF}};
        ex = '{{4'b1100, 16'hA5A5}, {4'b0001, 16'hA5A5}, {4'b0001, 16'hA5A5},
               {4'b0010, 16'hA5A5}, {4'b0010, 16'h00FF}};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b0);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL turn_off[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
    endtask

    task automatic test_open_drain();
        stim_t st [10];
        exp_t  ex [10];
        exp_t  e, g;
        st = '{{3'b101, 16'h00FF}, {3'b101, 16'h00FF}, {3'b101, 16'h00FF}, {3'b101, 16'h00FF},
               {3'b111, 16'h00FF}, {3'b101, 16'h00FF}, {3'b001, 16'h00FF}, {3'b001, 16'h00FF},
               {3'b001, 16'h00FF}, {3'b001, 16'h00FF}};
        ex = '{{4'b0010, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0100, 16'h00FF},
               {4'b0000, 16'h00FF}, {4'b0100, 16'h00FF}, {4'b0100, 16'h00FF}, {4'b0001, 16'h00FF},
               {4'b0001, 16'h00FF}, {4'b0010, 16'h00FF}};
        for (int i = 0; i < 10; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b0);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL open_drain[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
    endtask

    task automatic test_pulse();
        stim_t st [9];
        exp_t  ex [9];
        exp_t  e, g;
        repeat (4) begin
            drive({3'b000, 16'h00FF});
            tick();
        end
        st = '{{3'b110, 16'h00FF}, {3'b010, 16'h00FF}, {3'b010, 16'h00FF},
               {3'b010, 16'h00FF}, {3'b010, 16'h00FF}, {3'b010, 16'h00FF},
               {3'b010, 16'h00FF}, {3'b010, 16'h00FF}, {3'b010, 16'h00FF}};
`ifdef PAD_TURN_ABORT_EN
        ex = '{{4'b0010, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0010, 16'h00FF},
               {4'b0010, 16'h00FF}, {4'b0010, 16'h00FF}, {4'b0010, 16'h00FF},
               {4'b0010, 16'h00FF}, {4'b0010, 16'h00FF}, {4'b0010, 16'h00FF}};
`else
        ex = '{{4'b0010, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0001, 16'h00FF},
               {4'b0001, 16'h00FF}, {4'b1100, 16'h00FF}, {4'b0001, 16'h00FF},
               {4'b0001, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0010, 16'h00FF}};
`endif
        for (int i = 0; i < 9; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b1);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL pulse[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
    endtask

    task automatic test_reset_mid_turnaround();
        stim_t st [7];
        exp_t  ex [7];
        exp_t  e, g;
        st = '{{3'b110, 16'h00FF}, {3'b110, 16'h00FF}, {3'b110, 16'h00FF}, {3'b110, 16'h00FF},
               {3'b110, 16'h00FF}, {3'b010, 16'h00FF}, {3'b010, 16'h00FF}};
        ex = '{{4'b0010, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0001, 16'h00FF}, {4'b0001, 16'h00FF},
               {4'b1100, 16'h00FF}, {4'b1100, 16'h00FF}, {4'b0001, 16'h00FF}};
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            g = obs(1'b1);
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL mid_turn[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
        // Assert reset between clock edges; outputs must clear without an edge.
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            g = obs(d[0]);
            checks++;
            if (g !== {4'b0010, 16'h0000}) begin
                fails++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", d, g, {4'b0010, 16'h0000});
            end else passes++;
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        drive({3'b000, 16'h00FF});
        tick();
        for (int d = 0; d < 2; d++) begin
            g = obs(d[0]);
            checks++;
            if (g !== {4'b0010, 16'h00FF}) begin
                fails++;
                $display("FAIL post_reset dut%0d got=%h exp=%h", d, g, {4'b0010, 16'h00FF});
            end else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_turn_on();
        test_drive_data();
        test_turn_off();
        test_open_drain();
        test_pulse();
        test_reset_mid_turnaround();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pad_out_turnaround.md
Name: pad_out_turnaround

Overview:
- Sequential output-side controller for a bidirectional pad; the counterpart to the input pad cell.
- Registers core output data and enable, and applies pad attributes.
- Inserts TURN_CYCLES hi-Z guard cycles whenever the pad changes direction, so the pad and the external device never drive at the same time.
- Tells the input side when sampled pad data is valid. Sits between the pad-control logic and the pad ring.

Parameters:
- PADATTR, 16: width of the pad attribute bus.
- TURN_CYCLES, 2: guard cycles per direction change; 0 means a direct switch.
- PADATTR_RND, PADATTR==0 ? 1 : PADATTR: derived width; never overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- pad_out_i  in  1  data the core wants to drive.
- pad_oe_i  in  1  core direction request (1 = drive).
- od_i  in  1  open-drain mode select.
- pad_attributes_i  in  PADATTR_RND  requested attributes.
- pad_o  out  1  data to pad cell.
- pad_oe_o  out  1  output enable to pad cell.
- pad_attr_o  out  PADATTR_RND  applied attributes.
- in_valid_o  out  1  pad is released and settled; input data usable.
- busy_o  out  1  turnaround in progress.

Behaviour:
- States: HIZ, TURN_ON, DRIVE, TURN_OFF.
- Counter: cnt is $clog2(TURN_CYCLES+1) bits, minimum 1 bit.
- Reset (async, immediate even mid-turnaround):
  - state=HIZ, cnt=0, data register=0, pad_attr_o=0.
  - Outputs: pad_o=0, pad_oe_o=0, in_valid_o=1, busy_o=0.
- HIZ:
  - pad_oe_o=0, in_valid_o=1.
  - pad_attr_o <= pad_attributes_i every cycle; this is the only state where attributes update.
  - If pad_oe_i=1: go to TURN_ON with cnt=TURN_CYCLES-1, or straight to DRIVE if TURN_CYCLES==0.
- TURN_ON:
  - pad_oe_o=0, in_valid_o=0, busy_o=1.
  - pad_oe_i ignored (see Optional Feature).
  - cnt==0 -> DRIVE, else decrement.
- DRIVE:
  - Data register <= pad_out_i each cycle, giving one cycle of latency to pad_o.
  - Push-pull (od_i=0): pad_oe_o=1, pad_o=data register.
  - Open-drain (od_i=1): pad_o=0, pad_oe_o=~data register.
  - in_valid_o=0.
  - If pad_oe_i=0: go to TURN_OFF with cnt=TURN_CYCLES-1, or straight to HIZ if TURN_CYCLES==0.
  - pad_oe_o is 0 from the cycle after the deassert is sampled.
- TURN_OFF:
  - pad_oe_o=0, in_valid_o=0, busy_o=1.
  - pad_oe_i ignored, no exceptions.
  - cnt==0 -> HIZ, else decrement.
- Latency: pad_oe_i rise sampled at edge t -> pad_oe_o=1 after edge t+1+TURN_CYCLES. Fall sampled at t -> in_valid_o=1 after edge t+1+TURN_CYCLES.
- Invariant: pad_oe_o=1 and in_valid_o=1 never hold together. Under `ifndef SYNTHESIS`, violating this raises $error.
- A request toggled back within a turnaround is seen only after the turnaround finishes. Example: pad_oe_i pulses 1 then 0 during TURN_ON -> DRIVE for exactly one cycle, then TURN_OFF.
- pad_oe_o, pad_o, in_valid_o and busy_o are decoded from registers only; there is no combinational path from inputs.

Optional Feature:
- Macro: PAD_TURN_ABORT_EN.
- Defined: in TURN_ON with pad_oe_i=0, next state is HIZ. in_valid_o returns to 1 on the next cycle and there is no DRIVE cycle. This is safe because the pad was never driven. TURN_OFF is still never aborted.
- Undefined: behaviour as described above; the turnaround always completes.

Decomposition:
- Shared package pad_ctrl_pkg:
  - pad_turn_state_e enum (HIZ, TURN_ON, DRIVE, TURN_OFF), 2 bits.
  - Function turn_cnt_width(TURN_CYCLES).
- One natural sub-module, pad_turn_cnt:
  - Loadable down-counter with load, dec and zero_o.
  - Reused for both turnaround states.

Test Plan:
- Reset release, TURN_CYCLES=2, all inputs 0 -> pad_oe_o=0, in_valid_o=1, pad_attr_o tracks pad_attributes_i=16'hA5A5 one cycle later.
- pad_oe_i=1 at edge 5, pad_out_i=1 -> busy_o=1 at edges 6-7; pad_oe_o=1, pad_o=1 after edge 8; in_valid_o=0 from edge 6.
- In DRIVE, pad_oe_i=0 at edge 20 -> pad_oe_o=0 after edge 21; in_valid_o=1 after edge 23.
- Attributes changed to 16'h00FF while driving -> pad_attr_o holds its old value until the first HIZ cycle, then shows 00FF.
- od_i=1, pad_out_i sequence 0,1,0 in DRIVE -> pad_o=0 throughout; pad_oe_o sequence 1,0,1, delayed one cycle.
- pad_oe_i 1-cycle pulse, TURN_CYCLES=3:
  - Without macro: exactly one DRIVE cycle, then full TURN_OFF.
  - With PAD_TURN_ABORT_EN: pad_oe_o never rises; in_valid_o=1 two cycles after the pulse.
  - Under both configurations, rst_i asserted during TURN_OFF -> outputs return to reset values immediately, without waiting for a clock edge.
